serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single full-adder stage is reused across
// WIDTH cycles, LSB first, one bit per clock. Operands are taken with a
// valid/ready handshake and the result is offered on a second valid/ready
// handshake.
//
// Timing: operands are accepted on edge E0. Edges E1..E(WIDTH) each process
// one bit. out_valid is high from E(WIDTH) until the result handshake. The
// handshake edge returns the block to IDLE. The earliest following acceptance
// is one edge later, so one operation takes at least WIDTH+2 cycles.
//
// Parameters
//   WIDTH      operand/result width in bits (1..32)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   block can accept operands (high only in IDLE)
//   a, b, cin  operands and carry-in, sampled on acceptance
//   sub        (SERIAL_ADD_SUB_EN only) subtract select, sampled on acceptance
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes result
//   sum, cout  result and final carry. They keep the last result until the
//              next operation completes.
//   busy       high while an operation is in progress or awaiting handshake
//
// Optional feature
//   `define SERIAL_ADD_SUB_EN adds the sub port. When sub=1, the block computes
//   a-b. It does this as a + ~b + 1 and ignores cin. cout is then the
//   "no borrow" flag, which is 1 when a >= b.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // The counter only needs to hold 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;

  // Operand shift registers. Bit 0 is always the bit being processed.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Result bits enter at the MSB side of the accumulator. The accumulator
  // is kept separate from sum_q so that the visible result stays unchanged
  // until the new one is complete.
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               accept;
  logic               last_bit;
  logic               bit_s;
  logic               bit_c;
  logic [WIDTH:0]     acc_shift;
  logic [WIDTH-1:0]   b_eff;
  logic               carry_init;

  // ---------------------------------------------------------------------------
  // Single full-adder stage
  // ---------------------------------------------------------------------------
  assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign acc_shift = {bit_s, acc_q};

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_bit  = (count_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert b and inject a carry of 1.
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_eff      = b;
  assign carry_init = cin;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)  state_d = RUN;
      RUN:  if (last_bit)  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready  = 1'b1;
      RUN:  busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    count_d = count_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = carry_init;
          count_d = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        count_d = count_q + CNT_W'(1);
        acc_d   = acc_shift[WIDTH:1];
        // On the final bit, the result is published straight from the
        // adder output. This makes sum/cout valid on the same edge that
        // enters DONE.
        if (last_bit) begin
          sum_d  = acc_shift[WIDTH:1];
          cout_d = bit_c;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH=8). Directed cases and
// random operations are compared against plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int           n_checks;
  int           n_bad;

  // Last completed result. The DUT must keep presenting this while idle.
  logic [W-1:0] held_sum;
  logic         held_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Runs one full operation. The result is held in DONE for 'hold' cycles
  // while in_valid is toggled with junk. During the handshake cycle, in_valid
  // is held high to confirm that no same-cycle acceptance occurs.
  task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic cin_i, input logic sub_i, input int hold);
    int           full;
    int           lat;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic [W-1:0] s0;
    logic         c0;

    if (sub_i) begin
      full     = int'(a_i) - int'(b_i);
      exp_sum  = W'(full);
      exp_cout = (a_i >= b_i);
    end else begin
      full     = int'(a_i) + int'(b_i) + int'(cin_i);
      exp_sum  = W'(full);
      exp_cout = full[W];
    end

    @(negedge clk);
    check_val("idle_rdy", 32'(in_ready), 32'd1);
    check_val("idle_hold_sum", 32'(sum), 32'(held_sum));
    check_val("idle_hold_cout", 32'(cout), 32'(held_cout));
    a        = a_i;
    b        = b_i;
    cin      = cin_i;
`ifdef SERIAL_ADD_SUB_EN
    sub      = sub_i;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub      = 1'($urandom);
`endif
    check_val("run_rdy", 32'(in_ready), 32'd0);
    check_val("run_busy", 32'(busy), 32'd1);

    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", 32'(lat), 32'(W));
    check_val("sum", 32'(sum), 32'(exp_sum));
    check_val("cout", 32'(cout), 32'(exp_cout));
    $display("op a=0x%02h b=0x%02h cin=%0d sub=%0d -> sum=0x%02h cout=%0d (exp 0x%02h %0d) lat=%0d",
             a_i, b_i, cin_i, sub_i, sum, cout, exp_sum, exp_cout, lat);

    s0 = sum;
    c0 = cout;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      @(posedge clk);
      #1;
      check_val("hold_ov", 32'(out_valid), 32'd1);
      check_val("hold_rdy", 32'(in_ready), 32'd0);
      check_val("hold_sum", 32'({cout, sum}), 32'({c0, s0}));
    end

    // The handshake edge must return the block to IDLE without accepting
    // the in_valid that is presented in the same cycle.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("rel_ov", 32'(out_valid), 32'd0);
    check_val("rel_busy", 32'(busy), 32'd0);
    check_val("rel_rdy", 32'(in_ready), 32'd1);
    held_sum  = exp_sum;
    held_cout = exp_cout;
  endtask

  initial begin
    int seen;
    n_checks  = 0;
    n_bad     = 0;
    held_sum  = '0;
    held_cout = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub       = 1'b0;
`endif
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check_val("rst_rdy", 32'(in_ready), 32'd1);
    check_val("rst_ov", 32'(out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(8'h03, 8'h05, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 5);
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 2);

    // Abort mid-operation: reset during the 4th RUN cycle
    @(negedge clk);
    a        = 8'h5A;
    b        = 8'hA7;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_rdy", 32'(in_ready), 32'd1);
    check_val("abort_ov", 32'(out_valid), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_sum", 32'(sum), 32'd0);
    check_val("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    held_sum  = '0;
    held_cout = 1'b0;
    seen = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("abort_no_ov", 32'(seen), 32'd0);
    $display("abort test: out_valid seen %0d times after reset", seen);
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 1);
    run_op(8'h40, 8'h40, 1'b1, 1'b1, 0);
`endif

    // Random operations
    for (int n = 0; n < 40; n++) begin
      logic s_r;
`ifdef SERIAL_ADD_SUB_EN
      s_r = 1'($urandom);
`else
      s_r = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s_r, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
